pulp_io_evt_serializer: RTL and testbench

Sits directly downstream of the IO subsystem's uDMA event outputs (`events_o`, 32 peripherals × 4 channels). It captures single-cycle event pulses into per-line pending bits and selects one pending line per cycle with a round-robin arbiter. Each selected line becomes an 8-bit event ID that the block delivers through a small FIFO on a valid/ready stream toward the SoC event unit. Pulses that arrive on a line that is still pending are flagged as overflow.

---
 rtl/pulp_io_evt_serializer.sv | 123 ++++++++++++
 tb/tb_pulp_io_evt_serializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pulp_io_evt_serializer.sv
// Captures uDMA event pulses into pending bits, round-robin selects one per cycle and streams IDs through a FIFO.
// Optional saturating overflow counter enabled by defining PULP_IO_EVT_OVF_CNT_EN.
module pulp_io_evt_serializer #(
    parameter int unsigned NUM_EVT    = 128,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_ni,
    input  logic [NUM_EVT-1:0]  evt_i,
    input  logic [NUM_EVT-1:0]  evt_mask_i,
    output logic                evt_valid_o,
    output logic [ID_WIDTH-1:0] evt_data_o,
    input  logic                evt_ready_i,
    output logic                ovf_o,
    output logic [ID_WIDTH-1:0] ovf_id_o,
    output logic [15:0]         ovf_cnt_o,
    input  logic                ovf_clr_i
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [NUM_EVT-1:0]  pend_q, pend_d, set_vec, gnt_vec, ovf_vec;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                hi_v, lo_v, gnt_v, ovf_any;
    logic [ID_WIDTH-1:0] hi_idx, lo_idx, gnt_idx, ovf_idx;
    logic [ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q;
    logic                pop;
    logic                ovf_q;
    logic [ID_WIDTH-1:0] ovf_id_q;

    // Two lowest-index searches: one restricted to indices >= rr_ptr, one over all lines for the wrap case.
    always_comb begin
        hi_v   = 1'b0;
        lo_v   = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lo_v   = 1'b1;
                lo_idx = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= rr_ptr_q) begin
                    hi_v   = 1'b1;
                    hi_idx = ID_WIDTH'(i);
                end
            end
        end
    end

    assign gnt_v   = lo_v && (cnt_q < CW'(FIFO_DEPTH));
    assign gnt_idx = hi_v ? hi_idx : lo_idx;
    assign gnt_vec = gnt_v ? (NUM_EVT'(1) << gnt_idx) : '0;
    assign set_vec = evt_i & evt_mask_i;
    assign ovf_vec = set_vec & pend_q & ~gnt_vec;
    assign pend_d  = (pend_q & ~gnt_vec) | set_vec;
    assign pop     = (cnt_q != '0) && evt_ready_i;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_v) begin
            rr_ptr_d = (gnt_idx == ID_WIDTH'(NUM_EVT - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
        end
    end

    always_comb begin
        ovf_any = 1'b0;
        ovf_idx = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (ovf_vec[i]) begin
                ovf_any = 1'b1;
                ovf_idx = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            pend_q   <= '0;
            rr_ptr_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ovf_id_q <= '0;
            for (int k = 0; k < int'(FIFO_DEPTH); k++) mem_q[k] <= '0;
        end else begin
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            ovf_q    <= ovf_any;
            if (ovf_any) ovf_id_q <= ovf_idx;
            if (gnt_v) begin
                mem_q[wr_q] <= gnt_idx;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            if (gnt_v && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (!gnt_v && pop) cnt_q <= cnt_q - CW'(1);
        end
    end

    assign evt_valid_o = (cnt_q != '0);
    assign evt_data_o  = mem_q[rd_q];
    assign ovf_o       = ovf_q;
    assign ovf_id_o    = ovf_id_q;

`ifdef PULP_IO_EVT_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni)                     ovf_cnt_q <= '0;
        else if (ovf_clr_i)                  ovf_cnt_q <= '0;
        else if (ovf_any && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign ovf_cnt_o      = '0;
`endif
endmodule

// File: tb/tb_pulp_io_evt_serializer.sv
// Randomized and directed bench for pulp_io_evt_serializer against a queue-based reference model.
module tb_pulp_io_evt_serializer;
    localparam int N = 128;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] evt, mask;
    logic         rdy, clr;
    logic         valid, ovf;
    logic [7:0]   data, ovf_id;
    logic [15:0]  ovf_cnt;

    pulp_io_evt_serializer #(.NUM_EVT(N), .ID_WIDTH(8), .FIFO_DEPTH(D)) dut (
        .sys_clk_i(clk), .sys_rst_ni(rst_n), .evt_i(evt), .evt_mask_i(mask),
        .evt_valid_o(valid), .evt_data_o(data), .evt_ready_i(rdy),
        .ovf_o(ovf), .ovf_id_o(ovf_id), .ovf_cnt_o(ovf_cnt), .ovf_clr_i(clr)
    );

    always #5 clk = ~clk;

    bit m_pend [N];
    int m_rr, m_ovf_id, m_cnt;
    bit m_ovf;
    int m_q [$];
    int acc [$];
    int total = 0, bad = 0;
    int valid_seen, ovf_pulses, last_ovf_id;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model advance from pre-edge inputs, one clock edge, then compare all outputs.
    task automatic step();
        int g, oid;
        bit any;
        bit np [N];
        g = -1; any = 1'b0; oid = m_ovf_id;
        if (valid && rdy && rst_n) acc.push_back(int'(data));
        if (!rst_n) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_rr = 0; m_q.delete(); m_ovf = 0; m_ovf_id = 0; m_cnt = 0;
        end else begin
            if (m_q.size() < D)
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (g < 0 && m_pend[idx]) g = idx;
                end
            for (int i = N - 1; i >= 0; i--) begin
                bit s;
                s = evt[i] & mask[i];
                if (s && m_pend[i] && i != g) begin any = 1'b1; oid = i; end
                np[i] = (m_pend[i] && i != g) || s;
            end
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (g >= 0) begin m_q.push_back(g); m_rr = (g + 1) % N; end
            m_pend = np; m_ovf = any; m_ovf_id = oid;
`ifdef PULP_IO_EVT_OVF_CNT_EN
            if (clr) m_cnt = 0;
            else if (any && m_cnt < 65535) m_cnt++;
`endif
        end
        @(posedge clk); #1;
        chk("valid", int'(valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) chk("data", int'(data), m_q[0]);
        chk("ovf", int'(ovf), int'(m_ovf));
        if (m_ovf) chk("ovf_id", int'(ovf_id), m_ovf_id);
        chk("ovf_cnt", int'(ovf_cnt), m_cnt);
        if (valid) valid_seen++;
        if (ovf) begin ovf_pulses++; last_ovf_id = int'(ovf_id); end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; evt = '0; mask = '1; clr = 1'b0;
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_cnt;
        rst_n = 1'b0; evt = '0; mask = '1; rdy = 1'b1; clr = 1'b0;
        valid_seen = 0; ovf_pulses = 0; last_ovf_id = 0;
        do_reset();
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_ovf_id", int'(ovf_id), 0);
        chk("rst_cnt", int'(ovf_cnt), 0);

        // Single event: visible exactly two cycles after the pulse, for one cycle.
        rdy = 1'b1; evt[5] = 1'b1; step(); evt = '0;
        chk("single_t1", int'(valid), 0);
        step();
        chk("single_t2_valid", int'(valid), 1);
        chk("single_t2_data", int'(data), 5);
        step();
        chk("single_t3_valid", int'(valid), 0);

        // Round-robin wrap from rr_ptr=100.
        do_reset(); rdy = 1'b1;
        evt[99] = 1'b1; step(); evt = '0; steps(4);
        acc.delete();
        evt[3] = 1'b1; evt[127] = 1'b1; evt[0] = 1'b1; step(); evt = '0; steps(6);
        chk("wrap_n", acc.size(), 3);
        if (acc.size() == 3) begin
            chk("wrap_0", acc[0], 127);
            chk("wrap_1", acc[1], 0);
            chk("wrap_2", acc[2], 3);
        end

        // Backpressure: four queued, two held pending, then drained without gaps.
        do_reset(); rdy = 1'b0;
        evt[5:0] = '1; step(); evt = '0; steps(6);
        chk("bp_valid", int'(valid), 1);
        chk("bp_data", int'(data), 0);
        chk("bp_model_q", m_q.size(), 4);
        rdy = 1'b1; acc.delete(); steps(6);
        chk("bp_n", acc.size(), 6);
        foreach (acc[i]) chk("bp_order", acc[i], i);

        // Overflow on line 9 with a full FIFO.
        do_reset(); rdy = 1'b0;
        evt[3:0] = '1; step(); evt = '0; steps(5);
        ovf_pulses = 0;
        evt[9] = 1'b1; step(); evt = '0; step();
        evt[9] = 1'b1; step(); evt = '0; steps(2);
`ifdef PULP_IO_EVT_OVF_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("ovf_pulses", ovf_pulses, 1);
        chk("ovf_last_id", last_ovf_id, 9);
        chk("ovf_cnt_val", int'(ovf_cnt), exp_cnt);
`ifdef PULP_IO_EVT_OVF_CNT_EN
        evt[9] = 1'b1; steps(70000); evt = '0;
        chk("sat_cnt", int'(ovf_cnt), 65535);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_cnt", int'(ovf_cnt), 0);
`endif

        // Masked line produces nothing.
        do_reset(); rdy = 1'b1;
        mask[7] = 1'b0; evt[7] = 1'b1; step(); evt = '0;
        valid_seen = 0; steps(5);
        chk("mask_none", valid_seen, 0);
        mask = '1;

        // Reset with three IDs queued.
        do_reset(); rdy = 1'b0;
        evt[2:0] = '1; step(); evt = '0; steps(4);
        chk("rmid_q", m_q.size(), 3);
        chk("rmid_valid_pre", int'(valid), 1);
        rst_n = 1'b0; step();
        chk("rmid_valid", int'(valid), 0);
        chk("rmid_data", int'(data), 0);
        rst_n = 1'b1; rdy = 1'b1; valid_seen = 0; steps(10);
        chk("rmid_stale", valid_seen, 0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                evt[i]  = ($urandom_range(0, 15) == 0);
                mask[i] = ($urandom_range(0, 15) != 0);
            end
            rdy   = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; evt = '0; clr = 1'b0; rdy = 1'b1;
        steps(N + 2 * D);
        chk("drain_empty", int'(valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
